// File: rtl/timer_bank.sv
// Bank of NUM_CH prescaled down-counting timers on a word-addressed bus,
// with sticky write-1-to-clear interrupt status and per-channel IRQ export.
module timer_bank #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] ADD_I,
    input  logic              WE_I,
    input  logic [31:0]       DAT_I,
    output logic [31:0]       DAT_O,
    output logic              IRQ_O,
    output logic [NUM_CH-1:0] IRQ_VEC
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_CNT    = 2'd2,
        S_EXPIRE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [1:0]       MODE_RELOAD = 2'd1;
    localparam logic [1:0]       MODE_FREE   = 2'd2;

    state_t            state_q  [NUM_CH];
    state_t            state_d  [NUM_CH];
    logic [1:0]        mode_q   [NUM_CH];
    logic [1:0]        mode_d   [NUM_CH];
    logic [7:0]        presc_q  [NUM_CH];
    logic [7:0]        presc_d  [NUM_CH];
    logic [7:0]        pc_q     [NUM_CH];
    logic [7:0]        pc_d     [NUM_CH];
    logic [CNT_W-1:0]  preset_q [NUM_CH];
    logic [CNT_W-1:0]  preset_d [NUM_CH];
    logic [CNT_W-1:0]  count_q  [NUM_CH];
    logic [CNT_W-1:0]  count_d  [NUM_CH];
    logic [31:0]       rd_word_s[NUM_CH];
    logic [NUM_CH-1:0] en_q, en_d, im_q, im_d, pend_q, pend_d;
    logic [NUM_CH-1:0] sel_s, ctrl_wr_s, preset_wr_s, status_wr_s, tick_s;
    logic [31:0]       ch_idx_s;
    logic [1:0]        reg_idx_s;
    logic [31:0]       dat_o_s;
    logic              unused_s;

    assign ch_idx_s    = 32'(ADD_I[ADDR_W-1:4]);
    assign reg_idx_s   = ADD_I[3:2];
    assign unused_s    = ^ADD_I[1:0];
    assign ctrl_wr_s   = {NUM_CH{WE_I && (reg_idx_s == 2'd0)}} & sel_s;
    assign preset_wr_s = {NUM_CH{WE_I && (reg_idx_s == 2'd1)}} & sel_s;
    assign status_wr_s = {NUM_CH{WE_I && (reg_idx_s == 2'd3) && DAT_I[0]}} & sel_s;

    // Channel select and per-channel read word; out-of-range channels never match.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sel_s[i]  = (ch_idx_s == 32'(i));
            tick_s[i] = (pc_q[i] == presc_q[i]);
            case (reg_idx_s)
                2'd0:    rd_word_s[i] = {16'h0000, presc_q[i], 4'h0, im_q[i], mode_q[i], en_q[i]};
                2'd1:    rd_word_s[i] = 32'(preset_q[i]);
                2'd2:    rd_word_s[i] = 32'(count_q[i]);
                2'd3:    rd_word_s[i] = {31'h0000_0000, pend_q[i]};
                default: rd_word_s[i] = 32'h0000_0000;
            endcase
        end
    end

    // Read data mux: OR of the selected channel's word.
    always_comb begin
        dat_o_s = 32'h0000_0000;
        for (int i = 0; i < NUM_CH; i++) begin
            dat_o_s = dat_o_s | (sel_s[i] ? rd_word_s[i] : 32'h0000_0000);
        end
    end

    assign DAT_O   = dat_o_s;
    assign IRQ_VEC = pend_q & im_q;
    assign IRQ_O   = |IRQ_VEC;

    // Next state: bus writes first, then the FSM; expiry set beats W1C.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            pc_d[i]    = pc_q[i];
            if (ctrl_wr_s[i]) begin
                en_d[i]    = DAT_I[0];
                mode_d[i]  = DAT_I[2:1];
                im_d[i]    = DAT_I[3];
                presc_d[i] = DAT_I[15:8];
            end else begin
                en_d[i]    = en_q[i];
                mode_d[i]  = mode_q[i];
                im_d[i]    = im_q[i];
                presc_d[i] = presc_q[i];
            end
            if (preset_wr_s[i]) begin
                preset_d[i] = DAT_I[CNT_W-1:0];
            end else begin
                preset_d[i] = preset_q[i];
            end
            if (status_wr_s[i]) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
            case (state_q[i])
                S_IDLE: begin
                    state_d[i] = en_q[i] ? S_LOAD : S_IDLE;
                end
                S_LOAD: begin
                    count_d[i] = preset_q[i];
                    pc_d[i]    = 8'd0;
                    state_d[i] = S_CNT;
                end
                S_CNT: begin
                    if (!en_q[i]) begin
                        state_d[i] = S_IDLE;
                    end else if (tick_s[i]) begin
                        pc_d[i] = 8'd0;
                        // COUNT<=1 also covers PRESET=0, which expires on the first tick
                        if ((mode_q[i] != MODE_FREE) && (count_q[i] <= CNT_ONE)) begin
                            count_d[i] = '0;
                            pend_d[i]  = 1'b1;
                            state_d[i] = S_EXPIRE;
                        end else begin
                            count_d[i] = count_q[i] - CNT_ONE;
                        end
                    end else begin
                        pc_d[i] = pc_q[i] + 8'd1;
                    end
                end
                S_EXPIRE: begin
                    if (mode_q[i] == MODE_RELOAD) begin
                        count_d[i] = preset_q[i];
                        pc_d[i]    = 8'd0;
                        state_d[i] = S_CNT;
                    end else begin
                        en_d[i]    = ctrl_wr_s[i] ? DAT_I[0] : 1'b0;
                        state_d[i] = S_IDLE;
                    end
                end
                default: begin
                    state_d[i] = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            en_q   <= '0;
            im_q   <= '0;
            pend_q <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= S_IDLE;
                mode_q[i]   <= 2'd0;
                presc_q[i]  <= 8'd0;
                pc_q[i]     <= 8'd0;
                preset_q[i] <= '0;
                count_q[i]  <= '0;
            end
        end else begin
            en_q     <= en_d;
            im_q     <= im_d;
            pend_q   <= pend_d;
            state_q  <= state_d;
            mode_q   <= mode_d;
            presc_q  <= presc_d;
            pc_q     <= pc_d;
            preset_q <= preset_d;
            count_q  <= count_d;
        end
    end

endmodule
